axi_lite_reg_responder: RTL

- AXI4-Lite slave (responder) that terminates the processor subsystem's M_AXI master port, which is otherwise tied off in the top-level wrapper.
- Provides a small register window: ID, scratch, control outputs to fabric, raw status inputs from fabric, edge-latched interrupt pending/mask with a level interrupt out, and a free-running cycle counter.
- Sits between the system_ps_wrapper M_AXI port and fabric logic in the top level.

---
 rtl/axi_lite_reg_pkg.sv | 46 ++++
 rtl/axi_lite_reg_decode.sv | 39 +++
 rtl/axi_lite_reg_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Package for the AXI4-Lite register responder.
// Holds register offsets, register-select bit positions, response codes,
// FSM state encodings and the byte-strobe expansion helper shared by the
// decoder and the top level.
package axi_lite_reg_pkg;

    // Register offsets within the 32-byte window
    localparam logic [4:0] OFF_ID      = 5'h00;
    localparam logic [4:0] OFF_SCRATCH = 5'h04;
    localparam logic [4:0] OFF_CONTROL = 5'h08;
    localparam logic [4:0] OFF_STATUS  = 5'h0C;
    localparam logic [4:0] OFF_PENDING = 5'h10;
    localparam logic [4:0] OFF_MASK    = 5'h14;
    localparam logic [4:0] OFF_COUNTER = 5'h18;

    // Bit positions in the one-hot register select
    localparam int NUM_REGS    = 7;
    localparam int REG_ID      = 0;
    localparam int REG_SCRATCH = 1;
    localparam int REG_CONTROL = 2;
    localparam int REG_STATUS  = 3;
    localparam int REG_PENDING = 4;
    localparam int REG_MASK    = 5;
    localparam int REG_COUNTER = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Combinational address decoder for the register window.
// Ports:
//   addr   - byte address from the AW or AR channel
//   sel    - one-hot register select (bit positions from the package)
//   mapped - 1 when addr hits one of the seven implemented registers
// Address bits [1:0] are ignored; any bit above bit 4 set means unmapped.
module axi_lite_reg_decode
    import axi_lite_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_REGS-1:0]   sel,
    output logic                  mapped
);

    logic [4:0] offset;
    logic       upper_set;

    always_comb begin
        offset    = addr[4:0] & 5'b11100;
        upper_set = |(addr >> 5);
        sel       = '0;
        if (!upper_set) begin
            case (offset)
                OFF_ID:      sel[REG_ID]      = 1'b1;
                OFF_SCRATCH: sel[REG_SCRATCH] = 1'b1;
                OFF_CONTROL: sel[REG_CONTROL] = 1'b1;
                OFF_STATUS:  sel[REG_STATUS]  = 1'b1;
                OFF_PENDING: sel[REG_PENDING] = 1'b1;
                OFF_MASK:    sel[REG_MASK]    = 1'b1;
                OFF_COUNTER: sel[REG_COUNTER] = 1'b1;
                default:     sel              = '0;
            endcase
        end
        mapped = |sel;
    end

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder terminating the processor M_AXI port.
// Register window: ID, SCRATCH, CONTROL (driven to fabric), STATUS (live
// fabric input), IRQ_PENDING (edge-latched, W1C), IRQ_MASK, and a
// free-running COUNTER cleared by any write to it.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   s_axi_aw*/w*/b*    - AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*       - AXI4-Lite read address and data channels
//   ctrl_o             - CONTROL register contents
//   status_i           - fabric status, synchronous to clk
//   irq                - registered OR of pending & mask
module axi_lite_reg_responder
    import axi_lite_reg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h52554631,
    parameter logic [31:0] CTRL_RESET = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           ctrl_o,
    input  logic [31:0]           status_i,
    output logic                  irq
);

    wr_state_t            wr_state, wr_next;
    rd_state_t            rd_state, rd_next;
    logic [NUM_REGS-1:0]  wr_sel, rd_sel;
    logic                 wr_mapped, rd_mapped;
    logic                 wr_en;
    logic [31:0]          wmask, wmerge_scratch, wmerge_ctrl, wmerge_mask;
    logic [31:0]          pending_clr, status_edge, rd_value;
    logic [31:0]          scratch, pending, mask, counter, status_q;
    logic                 unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    axi_lite_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_decode (
        .addr   (s_axi_awaddr),
        .sel    (wr_sel),
        .mapped (wr_mapped)
    );

    axi_lite_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_decode (
        .addr   (s_axi_araddr),
        .sel    (rd_sel),
        .mapped (rd_mapped)
    );

    // Write channel FSM: AW and W are only taken together, ready is a
    // one-cycle pulse in W_ACK, and the address/data are still on the bus
    // during that cycle, so the register update uses them directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) wr_next = W_ACK;
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                wr_next       = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Read channel FSM: mirrors the write side with arready pulsed in R_ACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: if (s_axi_arvalid) rd_next = R_ACK;
            R_ACK: begin
                s_axi_arready = 1'b1;
                rd_next       = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_en          = (wr_state == W_ACK) && wr_mapped;
        wmask          = strb_mask(s_axi_wstrb);
        wmerge_scratch = (scratch & ~wmask) | (s_axi_wdata & wmask);
        wmerge_ctrl    = (ctrl_o  & ~wmask) | (s_axi_wdata & wmask);
        wmerge_mask    = (mask    & ~wmask) | (s_axi_wdata & wmask);
        pending_clr    = (wr_en && wr_sel[REG_PENDING]) ? (s_axi_wdata & wmask) : '0;
        status_edge    = status_i & ~status_q;
        // Unselected terms are zero, so an unmapped address reads as 0
        rd_value       = ({32{rd_sel[REG_ID]}}      & ID_VALUE) |
                         ({32{rd_sel[REG_SCRATCH]}} & scratch)  |
                         ({32{rd_sel[REG_CONTROL]}} & ctrl_o)   |
                         ({32{rd_sel[REG_STATUS]}}  & status_i) |
                         ({32{rd_sel[REG_PENDING]}} & pending)  |
                         ({32{rd_sel[REG_MASK]}}    & mask)     |
                         ({32{rd_sel[REG_COUNTER]}} & counter);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch     <= '0;
            ctrl_o      <= CTRL_RESET;
            mask        <= '0;
            pending     <= '0;
            counter     <= '0;
            status_q    <= '0;
            irq         <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            if (wr_en && wr_sel[REG_SCRATCH]) scratch <= wmerge_scratch;
            if (wr_en && wr_sel[REG_CONTROL]) ctrl_o  <= wmerge_ctrl;
            if (wr_en && wr_sel[REG_MASK])    mask    <= wmerge_mask;
            // Edge set is OR-ed after the clear so a simultaneous edge wins
            pending  <= (pending & ~pending_clr) | status_edge;
            counter  <= (wr_en && wr_sel[REG_COUNTER]) ? '0 : counter + 32'd1;
            status_q <= status_i;
            irq      <= |(pending & mask);
            if (wr_state == W_ACK) s_axi_bresp <= wr_mapped ? RESP_OKAY : RESP_DECERR;
        end
    end

    // Read data is captured on the same edge as any write update, so it
    // sees the pre-write register contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (rd_state == R_ACK) begin
            s_axi_rdata <= rd_value;
            s_axi_rresp <= rd_mapped ? RESP_OKAY : RESP_DECERR;
        end
    end

endmodule
